reaction_ctrl: RTL and testbench
================================

# reaction_ctrl

Trial sequencer for the reaction-time measurement path. It runs one reaction trial per `start`: a pseudo-random hold-off, then a lit stimulus, while generating the 1 ms enable pulses that drive the BCD millisecond counter chain. It latches the counter digits on the response, flags early and late responses, and keeps the best time since reset. It sits between the debounced user inputs and the four-digit time counter / late detector.

## Interface
- `TICK_DIV`, 100000: clk cycles per 1 ms tick; must be ≥ 2.
- `RND_MIN_MS`, 1000: minimum hold-off in ms; hold-off = `RND_MIN_MS` + lfsr[10:0], so 1000..3047 ms.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse, already debounced; begins a trial.
- `rxn` in 1: response button level, already debounced.
- `time_late` in 1: late flag from the 10 s detector.
- `d0`,`d1`,`d2`,`d3` in 4 each: live BCD counter digits, with d0 least significant.
- `time_clr` out 1: synchronous clear to the counter chain and late detector.
- `time_en` out 1: one-cycle 1 ms count pulse.
- `stim_led` out 1: stimulus indicator.
- `busy` out 1: trial in progress (WAIT or TIMING).
- `err_early`, `err_late` out 1 each: sticky trial-outcome flags.
- `res_valid` out 1: `result` holds a good measurement.
- `result` out 16: last measured time as BCD {d3,d2,d1,d0}.
- `best` out 16: lowest good `result` since reset, BCD.

## Operation
- States: IDLE, WAIT, TIMING, DONE, EARLY, LATE.
- IDLE, DONE, EARLY and LATE go to WAIT on `start`. On the same edge the hold-off counter is loaded with `RND_MIN_MS` + lfsr[10:0], 13 bits wide.
- WAIT, on `rxn`, goes to EARLY. `rxn` takes priority over hold-off expiry in the same cycle.
- WAIT, on a tick with hold-off == 1, goes to TIMING. Otherwise each tick decrements the hold-off counter.
- TIMING, on `time_late`, goes to LATE. This has priority over `rxn` in the same cycle.
- TIMING, on `rxn`, goes to DONE. On the same edge `result` ← {d3,d2,d1,d0}. If the captured value is below `best` (binary compare is valid for BCD), `best` is updated to it.
- `start` is ignored in WAIT and TIMING.
- Moore output decodes:
  - `time_clr` = 1 in IDLE, WAIT, EARLY and LATE.
  - `stim_led` = 1 in TIMING.
  - `busy` = 1 in WAIT and TIMING.
  - `err_early` = 1 in EARLY.
  - `err_late` = 1 in LATE.
  - `res_valid` = 1 in DONE.
- `time_en` = tick AND (state == TIMING). It is registered.
- Tick prescaler: counts 0..`TICK_DIV`-1. It restarts at 0 on entry to WAIT and to TIMING, so the first ms is always full length. Tick is high for the one cycle where count == `TICK_DIV`-1.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1. It advances every clk in all states and is never all-zero.

## Timing
- Reset values:
  - state IDLE, so `time_clr`=1.
  - `time_en`=0, `stim_led`=0, `busy`=0, `err_early`=0, `err_late`=0, `res_valid`=0.
  - `result`=16'h0000, `best`=16'h9999.
  - prescaler 0, lfsr 16'hACE1.
- `rst` mid-trial returns everything to the reset values on the next edge. `best` is also lost.
- `start` to `busy`=1: 1 cycle.
- Last hold-off tick to `stim_led`=1: 1 cycle. The first `time_en` follows `TICK_DIV` cycles later.
- `rxn` to `result`/`res_valid` update: 1 cycle. `result` equals the digits present in the `rxn` cycle.
- DONE holds the counter (`time_clr`=0, `time_en`=0), so the displayed digits stay equal to `result`.
- `result` and `best` are unchanged by EARLY and LATE trials.

## Structure
- Package `reaction_pkg`:
  - `state_t` enum.
  - LFSR seed and tap constant.
  - `BCD_MAX` = 16'h9999.
- Sub-module `ms_tick`: prescaler with inputs `restart` and `clk`/`rst`, output `tick`. Everything else is in one FSM module.

## Test plan
Run all scenarios with `TICK_DIV`=4 and `RND_MIN_MS`=2.

1. Reset -> IDLE, `time_clr`=1, all other outputs 0, `result`=0000, `best`=9999.
2. `start`, then `rxn` 250 `time_en` pulses after `stim_led` rises, with a behavioural counter model driving the digits -> DONE, `result`=0250, `best`=0250, `res_valid`=1. A second trial at 0180 -> `best`=0180. A third trial at 0300 -> `best` stays 0180.
3. `rxn` during WAIT -> EARLY next cycle, `err_early`=1, `stim_led` never asserted, `result`/`best` unchanged.
4. `time_late` in TIMING -> LATE, `err_late`=1, `time_clr`=1, `stim_led`=0.
5. `rxn` and `time_late` in the same TIMING cycle -> LATE, `result` unchanged. Also, hold-off expiry tick coincident with `rxn` in WAIT -> EARLY.
6. `rst` pulse mid-TIMING -> IDLE next cycle, `best`=9999. `start` in WAIT or TIMING -> ignored, and the hold-off counter is not reloaded.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial sequencer.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TIMING,
        ST_DONE,
        ST_EARLY,
        ST_LATE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] BCD_MAX   = 16'h9999;

    typedef struct packed {
        logic time_clr;
        logic stim_led;
        logic busy;
        logic err_early;
        logic err_late;
        logic res_valid;
    } out_t;

    function automatic out_t moore_out(input state_t s);
        out_t o;
        o           = '0;
        o.time_clr  = (s == ST_IDLE) || (s == ST_WAIT) || (s == ST_EARLY) || (s == ST_LATE);
        o.stim_led  = (s == ST_TIMING);
        o.busy      = (s == ST_WAIT) || (s == ST_TIMING);
        o.err_early = (s == ST_EARLY);
        o.err_late  = (s == ST_LATE);
        o.res_valid = (s == ST_DONE);
        return o;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/reaction_ctrl_ms_tick.sv
// 1 ms prescaler: tick is high for the single cycle where the count is TICK_DIV-1.
module ms_tick #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q;

    always_comb begin
        count_d = (restart || (count_q == LAST)) ? '0 : count_q + CW'(1);
    end

    // tick is registered from the next count so it coincides with count == LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= (count_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction trial sequencer: random hold-off, lit stimulus, result capture and best-time tracking.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned RND_MIN_MS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rxn,
    input  logic        time_late,
    input  logic [3:0]  d0,
    input  logic [3:0]  d1,
    input  logic [3:0]  d2,
    input  logic [3:0]  d3,
    output logic        time_clr,
    output logic        time_en,
    output logic        stim_led,
    output logic        busy,
    output logic        err_early,
    output logic        err_late,
    output logic        res_valid,
    output logic [15:0] result,
    output logic [15:0] best
);

    localparam int unsigned HW = 13;

    state_t          state_q;
    out_t            out_q;
    logic            time_en_q;
    logic [15:0]     result_q, best_q;
    logic [HW-1:0]   hold_q;
    logic [15:0]     lfsr_q;
    logic            tick;
    logic            go_wait_c, expire_c, restart_c;
    logic [15:0]     digits_c;
    logic [HW-1:0]   holdoff_c;

    assign go_wait_c = start && (state_q != ST_WAIT) && (state_q != ST_TIMING);
    assign expire_c  = (state_q == ST_WAIT) && !rxn && tick && (hold_q == HW'(1));
    assign restart_c = go_wait_c || expire_c;
    assign digits_c  = {d3, d2, d1, d0};
    assign holdoff_c = HW'(RND_MIN_MS) + {2'b00, lfsr_q[10:0]};

    ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_c),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_q     <= moore_out(ST_IDLE);
            time_en_q <= 1'b0;
            result_q  <= 16'h0000;
            best_q    <= BCD_MAX;
            hold_q    <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            lfsr_q    <= lfsr_next(lfsr_q);
            // no count pulse on the edge that leaves TIMING, so DONE shows exactly result
            time_en_q <= tick && (state_q == ST_TIMING) && !rxn && !time_late;
            case (state_q)
                ST_WAIT: begin
                    if (rxn) begin
                        state_q <= ST_EARLY;
                        out_q   <= moore_out(ST_EARLY);
                    end else if (expire_c) begin
                        state_q <= ST_TIMING;
                        out_q   <= moore_out(ST_TIMING);
                    end else if (tick) begin
                        hold_q  <= hold_q - HW'(1);
                    end
                end
                ST_TIMING: begin
                    if (time_late) begin
                        state_q <= ST_LATE;
                        out_q   <= moore_out(ST_LATE);
                    end else if (rxn) begin
                        state_q  <= ST_DONE;
                        out_q    <= moore_out(ST_DONE);
                        result_q <= digits_c;
                        if (digits_c < best_q) begin
                            best_q <= digits_c;
                        end
                    end
                end
                default: begin
                    if (go_wait_c) begin
                        state_q <= ST_WAIT;
                        out_q   <= moore_out(ST_WAIT);
                        hold_q  <= holdoff_c;
                    end
                end
            endcase
        end
    end

    assign time_clr  = out_q.time_clr;
    assign stim_led  = out_q.stim_led;
    assign busy      = out_q.busy;
    assign err_early = out_q.err_early;
    assign err_late  = out_q.err_late;
    assign res_valid = out_q.res_valid;
    assign time_en   = time_en_q;
    assign result    = result_q;
    assign best      = best_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a behavioural BCD counter driving the digit inputs.
module tb_reaction_ctrl;

    localparam int TD = 4;
    localparam int RM = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rxn = 1'b0;
    logic        time_late = 1'b0;
    logic [3:0]  d0, d1, d2, d3;
    logic        time_clr, time_en, stim_led, busy, err_early, err_late, res_valid;
    logic [15:0] result, best;

    int          cnt = 0;
    logic [15:0] m = 16'hACE1;
    int          checks = 0;
    int          errors = 0;
    int          exp_hold = 0;

    reaction_ctrl #(.TICK_DIV(TD), .RND_MIN_MS(RM)) dut (
        .clk(clk), .rst(rst), .start(start), .rxn(rxn), .time_late(time_late),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .time_clr(time_clr), .time_en(time_en), .stim_led(stim_led), .busy(busy),
        .err_early(err_early), .err_late(err_late), .res_valid(res_valid),
        .result(result), .best(best)
    );

    always #5 clk = ~clk;

    // reference LFSR, used to predict each hold-off
    always @(posedge clk) begin
        if (rst) m <= 16'hACE1;
        else     m <= m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    end

    // four-digit BCD millisecond counter
    always @(posedge clk) begin
        if (time_clr === 1'b1)     cnt <= 0;
        else if (time_en === 1'b1) cnt <= (cnt == 9999) ? 0 : cnt + 1;
    end
    assign d0 = 4'(cnt % 10);
    assign d1 = 4'((cnt / 10) % 10);
    assign d2 = 4'((cnt / 100) % 10);
    assign d3 = 4'((cnt / 1000) % 10);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic go_stim(input bit poke);
        int n;
        start = 1'b1;
        exp_hold = RM + int'(m[10:0]);
        step;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
        n = 0;
        while (stim_led !== 1'b1 && n < 20000) begin
            start = poke && (n == 2);
            step;
            n++;
        end
        start = 1'b0;
        checks++;
        if (n != TD * exp_hold) begin
            errors++; $display("FAIL holdoff_cycles: got %0d expected %0d", n, TD * exp_hold);
        end
    endtask

    task automatic measure(input int ms, input bit poke);
        int k, t, first;
        k = 0; t = 0; first = -1;
        while (k < ms && t < 20000) begin
            start = poke && (t == 10);
            step;
            t++;
            if (time_en === 1'b1) begin
                k++;
                if (first < 0) first = t;
            end
        end
        start = 1'b0;
        checks++;
        if (first != TD) begin errors++; $display("FAIL first_time_en: got %0d expected %0d", first, TD); end
        checks++;
        if (k != ms) begin errors++; $display("FAIL time_en_count: got %0d expected %0d", k, ms); end
        step;
        rxn = 1'b1;
        step;
        rxn = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step;
        rst = 1'b0;
        checks++;
        if ({time_clr, time_en, stim_led, busy, err_early, err_late, res_valid} !== 7'b1000000) begin
            errors++; $display("FAIL reset_outputs: got %b expected 1000000",
                {time_clr, time_en, stim_led, busy, err_early, err_late, res_valid});
        end
        checks++;
        if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++;
        if (best !== 16'h9999) begin errors++; $display("FAIL reset_best: got %h expected 9999", best); end
    endtask

    task automatic test_good(input int ms, input logic [15:0] exp_res, input logic [15:0] exp_best,
                             input bit poke);
        go_stim(poke);
        measure(ms, poke);
        checks++;
        if (result !== exp_res) begin errors++; $display("FAIL good_result: got %h expected %h", result, exp_res); end
        checks++;
        if (best !== exp_best) begin errors++; $display("FAIL good_best: got %h expected %h", best, exp_best); end
        checks++;
        if ({stim_led, busy, res_valid, time_clr, time_en} !== 5'b00100) begin
            errors++; $display("FAIL done_outputs: got %b expected 00100",
                {stim_led, busy, res_valid, time_clr, time_en});
        end
        repeat (3) step;
        checks++;
        if ({d3, d2, d1, d0} !== exp_res) begin
            errors++; $display("FAIL done_hold: got %h expected %h", {d3, d2, d1, d0}, exp_res);
        end
    endtask

    task automatic test_early;
        logic [15:0] r0, b0;
        bit seen;
        r0 = result; b0 = best; seen = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (5) begin
            step;
            if (stim_led === 1'b1) seen = 1'b1;
        end
        rxn = 1'b1;
        step;
        rxn = 1'b0;
        checks++;
        if ({err_early, busy, stim_led, time_clr} !== 4'b1001) begin
            errors++; $display("FAIL early_outputs: got %b expected 1001", {err_early, busy, stim_led, time_clr});
        end
        checks++;
        if (seen) begin errors++; $display("FAIL early_stim: got 1 expected 0"); end
        checks++;
        if ({result, best} !== {r0, b0}) begin
            errors++; $display("FAIL early_keep: got %h expected %h", {result, best}, {r0, b0});
        end
    endtask

    task automatic test_late;
        logic [15:0] r0;
        r0 = result;
        go_stim(1'b0);
        repeat (6) step;
        time_late = 1'b1;
        step;
        time_late = 1'b0;
        checks++;
        if ({err_late, time_clr, stim_led, busy, res_valid} !== 5'b11000) begin
            errors++; $display("FAIL late_outputs: got %b expected 11000",
                {err_late, time_clr, stim_led, busy, res_valid});
        end
        checks++;
        if (result !== r0) begin errors++; $display("FAIL late_result: got %h expected %h", result, r0); end
    endtask

    task automatic test_late_rxn;
        logic [15:0] r0;
        r0 = result;
        go_stim(1'b0);
        repeat (5) step;
        time_late = 1'b1;
        rxn = 1'b1;
        step;
        time_late = 1'b0;
        rxn = 1'b0;
        checks++;
        if ({err_late, res_valid, stim_led} !== 3'b100) begin
            errors++; $display("FAIL late_rxn_state: got %b expected 100", {err_late, res_valid, stim_led});
        end
        checks++;
        if (result !== r0) begin errors++; $display("FAIL late_rxn_result: got %h expected %h", result, r0); end
    endtask

    task automatic test_expiry_rxn;
        start = 1'b1;
        exp_hold = RM + int'(m[10:0]);
        step;
        start = 1'b0;
        repeat (TD * exp_hold - 1) step;
        checks++;
        if (stim_led !== 1'b0) begin errors++; $display("FAIL expiry_pre_stim: got %b expected 0", stim_led); end
        rxn = 1'b1;
        step;
        rxn = 1'b0;
        checks++;
        if ({err_early, stim_led, busy} !== 3'b100) begin
            errors++; $display("FAIL expiry_rxn_state: got %b expected 100", {err_early, stim_led, busy});
        end
    endtask

    task automatic test_reset_mid;
        go_stim(1'b0);
        repeat (10) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++;
        if ({time_clr, time_en, stim_led, busy, err_early, err_late, res_valid} !== 7'b1000000) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 1000000",
                {time_clr, time_en, stim_led, busy, err_early, err_late, res_valid});
        end
        checks++;
        if ({result, best} !== {16'h0000, 16'h9999}) begin
            errors++; $display("FAIL midreset_regs: got %h expected 00009999", {result, best});
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_good(250, 16'h0250, 16'h0250, 1'b0);
        test_good(180, 16'h0180, 16'h0180, 1'b0);
        test_good(300, 16'h0300, 16'h0180, 1'b1);
        test_early;
        test_late;
        test_late_rxn;
        test_expiry_rxn;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
